// File: rtl/hydration_reminder_fsm.sv
// Hydration reminder: BCD minute countdown, drink alert, snooze and missed-drink logging.
// Optional build macro ALERT_BLINK_EN makes the alert blink on secTick while in ALERT.
module hydration_reminder_fsm #(
   parameter int INTERVAL_MIN      = 30,
   parameter int SNOOZE_MIN        = 5,
   parameter int ALERT_TIMEOUT_MIN = 10
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       minTick,
   input  logic       secTick,
   input  logic       ack,
   input  logic       snooze,
   output logic [3:0] remTens,
   output logic [3:0] remOnes,
   output logic       alert,
   output logic [7:0] drinkCount,
   output logic [7:0] missedCount,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      COUNTDOWN = 2'd1,
      ALERT     = 2'd2,
      SNOOZE    = 2'd3
   } state_t;

   localparam logic [3:0] INT_T   = 4'(INTERVAL_MIN / 10);
   localparam logic [3:0] INT_O   = 4'(INTERVAL_MIN % 10);
   localparam logic [3:0] SNZ_T   = 4'(SNOOZE_MIN / 10);
   localparam logic [3:0] SNZ_O   = 4'(SNOOZE_MIN % 10);
   localparam logic [6:0] TO_LAST = 7'(ALERT_TIMEOUT_MIN - 1);

   state_t     state_q, state_d;
   logic [3:0] tens_q, tens_d, ones_q, ones_d;
   logic       alert_q, alert_d;
   logic [7:0] drink_q, drink_d, missed_q, missed_d;
   logic [6:0] timer_q, timer_d;
   logic       tickPrev;
   logic       tickEvt;

   assign tickEvt = minTick & ~tickPrev;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Returns {tens, ones} after a one-minute BCD decrement.
   function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] o);
      return (o == 4'd0) ? {t - 4'd1, 4'd9} : {t, o - 4'd1};
   endfunction

`ifndef ALERT_BLINK_EN
   logic unused_sectick;
   assign unused_sectick = secTick;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         tens_q   <= 4'd0;
         ones_q   <= 4'd0;
         alert_q  <= 1'b0;
         drink_q  <= 8'd0;
         missed_q <= 8'd0;
         timer_q  <= 7'd0;
         tickPrev <= 1'b0;
      end else begin
         state_q  <= state_d;
         tens_q   <= tens_d;
         ones_q   <= ones_d;
         alert_q  <= alert_d;
         drink_q  <= drink_d;
         missed_q <= missed_d;
         timer_q  <= timer_d;
         tickPrev <= minTick;
      end
   end

   always_comb begin
      state_d  = state_q;
      tens_d   = tens_q;
      ones_d   = ones_q;
      alert_d  = alert_q;
      drink_d  = drink_q;
      missed_d = missed_q;
      timer_d  = timer_q;
      if (!enable) begin
         state_d = IDLE;
         tens_d  = 4'd0;
         ones_d  = 4'd0;
         alert_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = COUNTDOWN;
               tens_d  = INT_T;
               ones_d  = INT_O;
               alert_d = 1'b0;
            end
            COUNTDOWN, SNOOZE: begin
               alert_d = 1'b0;
               if (ack) begin
                  state_d = COUNTDOWN;
                  tens_d  = INT_T;
                  ones_d  = INT_O;
                  drink_d = sat_inc(drink_q);
               end else if (tickEvt) begin
                  if (tens_q == 4'd0 && ones_q == 4'd1) begin
                     state_d = ALERT;
                     tens_d  = 4'd0;
                     ones_d  = 4'd0;
                     alert_d = 1'b1;
                     timer_d = 7'd0;
                  end else begin
                     {tens_d, ones_d} = bcd_dec(tens_q, ones_q);
                  end
               end
            end
            ALERT: begin
`ifdef ALERT_BLINK_EN
               if (secTick) alert_d = ~alert_q;
`else
               alert_d = 1'b1;
`endif
               // Leaving ALERT always forces the alert low, overriding any blink toggle.
               if (ack) begin
                  state_d = COUNTDOWN;
                  tens_d  = INT_T;
                  ones_d  = INT_O;
                  drink_d = sat_inc(drink_q);
                  alert_d = 1'b0;
               end else if (snooze) begin
                  state_d = SNOOZE;
                  tens_d  = SNZ_T;
                  ones_d  = SNZ_O;
                  alert_d = 1'b0;
               end else if (tickEvt) begin
                  if (timer_q == TO_LAST) begin
                     state_d  = COUNTDOWN;
                     tens_d   = INT_T;
                     ones_d   = INT_O;
                     missed_d = sat_inc(missed_q);
                     alert_d  = 1'b0;
                  end else begin
                     timer_d = timer_q + 7'd1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign state       = state_q;
   assign remTens     = tens_q;
   assign remOnes     = ones_q;
   assign alert       = alert_q;
   assign drinkCount  = drink_q;
   assign missedCount = missed_q;

endmodule

// File: tb/tb_hydration_reminder_fsm.sv
// Directed bench for hydration_reminder_fsm with a 12/2/2 minute configuration.
module tb_hydration_reminder_fsm;

   logic       clk = 1'b0;
   logic       reset, enable, minTick, secTick, ack, snooze;
   logic [3:0] remTens, remOnes;
   logic       alert;
   logic [7:0] drinkCount, missedCount;
   logic [1:0] state;

   hydration_reminder_fsm #(
      .INTERVAL_MIN(12), .SNOOZE_MIN(2), .ALERT_TIMEOUT_MIN(2)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .minTick(minTick), .secTick(secTick),
      .ack(ack), .snooze(snooze), .remTens(remTens), .remOnes(remOnes), .alert(alert),
      .drinkCount(drinkCount), .missedCount(missedCount), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, en, tk, ak, sn;
      logic [1:0] st;
      int         rem;
      logic       al;
      logic [7:0] dc, mc;
   } vec_t;

   vec_t vq[$];
   int   nvec = 0;
   int   nerr = 0;
   logic [7:0] edc = 8'd0;
   logic [7:0] emc = 8'd0;

   task automatic add(input logic rst, en, tk, ak, sn, input logic [1:0] st,
                      input int rem, input logic al);
      vec_t v;
      v.rst = rst; v.en = en; v.tk = tk; v.ak = ak; v.sn = sn;
      v.st = st; v.rem = rem; v.al = al; v.dc = edc; v.mc = emc;
      vq.push_back(v);
   endtask

   // Tick edges from rem=from down to ALERT entry, starting in state st.
   task automatic to_alert(input logic [1:0] st, input int from);
      for (int r = from - 1; r >= 1; r--) begin
         add(0, 1, 1, 0, 0, st, r, 0);
         add(0, 1, 0, 0, 0, st, r, 0);
      end
      add(0, 1, 1, 0, 0, 2'd2, 0, 1);
      add(0, 1, 0, 0, 0, 2'd2, 0, 1);
   endtask

   task automatic check(input string name, input logic [1:0] st, input int rem,
                        input logic al, input logic [7:0] dc, input logic [7:0] mc);
      logic [3:0] t, o;
      t = 4'(rem / 10);
      o = 4'(rem % 10);
      nvec++;
      if (state !== st || remTens !== t || remOnes !== o || alert !== al ||
          drinkCount !== dc || missedCount !== mc) begin
         nerr++;
         $display("FAIL %s: got st=%0d rem=%h%h alert=%b drink=%0d missed=%0d, want st=%0d rem=%h%h alert=%b drink=%0d missed=%0d",
                  name, state, remTens, remOnes, alert, drinkCount, missedCount,
                  st, t, o, al, dc, mc);
      end
   endtask

   task automatic cycle(input logic rst, en, tk, ak, sn, sec);
      reset = rst; enable = en; minTick = tk; ack = ak; snooze = sn; secTick = sec;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic       blink_al;
      logic [7:0] dsat;
      reset = 1'b1; enable = 1'b0; minTick = 1'b0; secTick = 1'b0; ack = 1'b0; snooze = 1'b0;

      // reset, enable, BCD borrow, held minTick
      add(1, 0, 0, 0, 0, 2'd0, 0, 0);
      add(0, 1, 0, 0, 0, 2'd1, 12, 0);
      add(0, 1, 1, 0, 0, 2'd1, 11, 0);
      add(0, 1, 0, 0, 0, 2'd1, 11, 0);
      add(0, 1, 1, 0, 0, 2'd1, 10, 0);
      add(0, 1, 0, 0, 0, 2'd1, 10, 0);
      add(0, 1, 1, 0, 0, 2'd1, 9, 0);
      add(0, 1, 0, 0, 0, 2'd1, 9, 0);
      for (int k = 0; k < 5; k++) add(0, 1, 1, 0, 0, 2'd1, 8, 0);
      add(0, 1, 0, 0, 0, 2'd1, 8, 0);
      to_alert(2'd1, 8);
      edc = 8'd1;
      add(0, 1, 0, 1, 0, 2'd1, 12, 0);
      // full 12-edge interval, snooze, snooze expiry, timeout
      to_alert(2'd1, 12);
      add(0, 1, 0, 0, 1, 2'd3, 2, 0);
      to_alert(2'd3, 2);
      add(0, 1, 1, 0, 0, 2'd2, 0, 1);
      add(0, 1, 0, 0, 0, 2'd2, 0, 1);
      emc = 8'd1;
      add(0, 1, 1, 0, 0, 2'd1, 12, 0);
      add(0, 1, 0, 0, 0, 2'd1, 12, 0);
      // ack beats snooze and tick in ALERT
      to_alert(2'd1, 12);
      edc = 8'd2;
      add(0, 1, 1, 1, 1, 2'd1, 12, 0);
      add(0, 1, 0, 0, 0, 2'd1, 12, 0);
      // early drink and ignored snooze in COUNTDOWN
      add(0, 1, 1, 0, 0, 2'd1, 11, 0);
      add(0, 1, 0, 0, 0, 2'd1, 11, 0);
      edc = 8'd3;
      add(0, 1, 0, 1, 0, 2'd1, 12, 0);
      add(0, 1, 0, 0, 1, 2'd1, 12, 0);
      // enable drop at 05, ticks ignored in IDLE, re-enable
      for (int r = 11; r >= 5; r--) begin
         add(0, 1, 1, 0, 0, 2'd1, r, 0);
         add(0, 1, 0, 0, 0, 2'd1, r, 0);
      end
      add(0, 0, 0, 0, 0, 2'd0, 0, 0);
      add(0, 0, 1, 1, 1, 2'd0, 0, 0);
      add(0, 0, 0, 0, 0, 2'd0, 0, 0);
      add(0, 1, 0, 0, 0, 2'd1, 12, 0);
      // reset while in ALERT
      to_alert(2'd1, 12);
      edc = 8'd0; emc = 8'd0;
      add(1, 1, 0, 0, 0, 2'd0, 0, 0);
      add(0, 1, 0, 0, 0, 2'd1, 12, 0);

      foreach (vq[i]) begin
         cycle(vq[i].rst, vq[i].en, vq[i].tk, vq[i].ak, vq[i].sn, 1'b0);
         check($sformatf("vec%0d", i), vq[i].st, vq[i].rem, vq[i].al, vq[i].dc, vq[i].mc);
      end

      // drinkCount saturation over 256 consecutive acks
      dsat = 8'd0;
      for (int i = 0; i < 256; i++) begin
         cycle(0, 1, 0, 1, 0, 0);
         if (dsat != 8'hFF) dsat = dsat + 8'd1;
         if (i >= 253) check($sformatf("sat_ack%0d", i), 2'd1, 12, 0, dsat, 8'd0);
      end
      cycle(0, 1, 0, 0, 0, 0);
      check("sat_hold", 2'd1, 12, 0, 8'd255, 8'd0);

      // secTick behaviour in ALERT
      for (int r = 11; r >= 0; r--) begin
         cycle(0, 1, 1, 0, 0, 0);
         cycle(0, 1, 0, 0, 0, 0);
      end
      check("blink_entry", 2'd2, 0, 1, 8'd255, 8'd0);
      for (int p = 0; p < 4; p++) begin
`ifdef ALERT_BLINK_EN
         blink_al = (p % 2 == 0) ? 1'b0 : 1'b1;
`else
         blink_al = 1'b1;
`endif
         cycle(0, 1, 0, 0, 0, 1);
         check($sformatf("blink_pulse%0d", p), 2'd2, 0, blink_al, 8'd255, 8'd0);
         cycle(0, 1, 0, 0, 0, 0);
         check($sformatf("blink_gap%0d", p), 2'd2, 0, blink_al, 8'd255, 8'd0);
      end
      cycle(0, 1, 0, 1, 0, 1);
      check("blink_exit", 2'd1, 12, 0, 8'd255, 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/hydration_reminder_fsm.md
Name: hydration_reminder_fsm

Overview:
- Downstream consumer of the seconds counter stage. Takes its minute carry as a minute tick, counts down a reminder interval in BCD for display, and raises a drink alert on expiry.
- The alert is cleared by acknowledge, deferred by snooze, or logged as missed after a timeout.
- Feeds the LED/buzzer driver and the 7-segment display mux.

Parameters:
- INTERVAL_MIN, 30, reminder interval in minutes; legal range 1..99.
- SNOOZE_MIN, 5, snooze length in minutes; legal range 1..99.
- ALERT_TIMEOUT_MIN, 10, minutes in ALERT without ack before the reminder counts as missed; legal range 1..99.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  reminder function on (level)
- minTick  in  1  minute carry from the seconds stage; level, may stay high more than one cycle
- secTick  in  1  one-cycle pulse per second; used only with ALERT_BLINK_EN
- ack  in  1  debounced one-cycle "drank" pulse
- snooze  in  1  debounced one-cycle snooze pulse
- remTens  out  4  BCD tens of minutes remaining
- remOnes  out  4  BCD ones of minutes remaining
- alert  out  1  drink alert to LED/buzzer
- drinkCount  out  8  binary count of acknowledged drinks; saturates at 255
- missedCount  out  8  binary count of timed-out alerts; saturates at 255
- state  out  2  IDLE=0, COUNTDOWN=1, ALERT=2, SNOOZE=3

Behaviour:
- One clock; reset is synchronous and active-high; all registers update on posedge clk.
- Reset values: state=IDLE, remTens=0, remOnes=0, alert=0, drinkCount=0, missedCount=0, tickPrev=0, alertTimer=0.
- Tick event: tickEvt = minTick & ~tickPrev; tickPrev <= minTick every cycle. A minTick held high for N cycles produces exactly one event.
- All outputs are registered. Every effect of tickEvt, ack or snooze appears one clock after the edge at which it is sampled.
- enable=0 in any state: next state IDLE, rem=00, alert=0. Counters are held, not cleared.
- IDLE with enable=1: go to COUNTDOWN; rem loaded with INTERVAL_MIN in BCD. tickEvt, ack and snooze are ignored in IDLE.
- COUNTDOWN:
  - tickEvt: rem decrements in BCD; ones 0 -> 9 with a borrow from tens.
  - tickEvt with rem=01: rem=00, go to ALERT, alert=1, alertTimer=0.
  - ack: reload INTERVAL_MIN and increment drinkCount (early drink).
  - snooze: ignored.
- ALERT:
  - alert=1, rem held at 00; tickEvt increments alertTimer.
  - ack: go to COUNTDOWN, reload INTERVAL_MIN, increment drinkCount, alert=0.
  - snooze: go to SNOOZE, rem=SNOOZE_MIN, alert=0.
  - tickEvt with alertTimer=ALERT_TIMEOUT_MIN-1: increment missedCount, go to COUNTDOWN, reload INTERVAL_MIN, alert=0.
- SNOOZE:
  - Counts down like COUNTDOWN.
  - Expiry (tickEvt at 01): go to ALERT, alertTimer=0.
  - ack: go to COUNTDOWN, reload INTERVAL_MIN, increment drinkCount.
  - snooze: ignored.
- Priority on simultaneous events: reset > ~enable > ack > snooze > tickEvt. A tick discarded by a higher-priority event is lost, not deferred.
- Saturation: drinkCount and missedCount stop at 255; there is no wrap.
- Reset mid-operation: state returns to IDLE next cycle regardless of inputs. With enable high, COUNTDOWN starts one cycle later.
- remTens and remOnes are always valid BCD, 0..9 each.

Optional Feature:
- ALERT_BLINK_EN defined: while in ALERT, alert toggles on each secTick pulse (1 s on / 1 s off) and starts high on ALERT entry.
- ALERT_BLINK_EN undefined: alert is steady high in ALERT and secTick is unused.
- In both builds, alert=0 outside ALERT.

Test Plan (sim overrides: INTERVAL_MIN=12, SNOOZE_MIN=2, ALERT_TIMEOUT_MIN=2):
- Reset, then enable=1 -> state=COUNTDOWN, rem=12. Apply 3 minTick edges -> rem=11, 10, 09 (BCD borrow verified). Hold minTick high 5 cycles -> rem=08, a single decrement.
- 12 tick edges -> alert=1 one cycle after the 12th edge is sampled, state=ALERT, rem=00. ack -> alert=0, rem=12, drinkCount=1.
- In ALERT, snooze -> state=SNOOZE, rem=02. 2 tick edges -> state=ALERT, alert=1. 2 more tick edges without ack -> missedCount=1, state=COUNTDOWN, rem=12.
- ack, snooze and tickEvt in the same cycle in ALERT -> ack wins: COUNTDOWN, rem=12, drinkCount increments, no snooze, no decrement.
- enable dropped mid-COUNTDOWN at rem=05 -> IDLE, rem=00, counts retained. Re-enable -> rem=12. Reset asserted in ALERT -> all outputs at reset values next cycle.
- 256 acks in COUNTDOWN -> drinkCount=255. With ALERT_BLINK_EN, 4 secTick pulses in ALERT -> alert sequence 1,0,1,0,1.
